ofm_writer: RTL and testbench

OFM_WRITER -- requirements
Module: ofm_writer

---
 rtl/ofm_writer.sv | 260 ++++++++++++++++++++++++++
 tb/tb_ofm_writer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofm_writer.sv
// ofm_writer
// Collects completed output-feature-map pixels from a 16-PE array and writes
// them to the OFM BRAM as four 32-bit words per pixel.
//
// A pixel is captured when all 16 PE valid flags are high. Captured pixels
// (128 bits, OFM_0 in the top byte) go into a small FIFO. A drainer emits the
// head entry as four consecutive BRAM words, OFM_0 in bits [31:24] of word 0.
//
// Parameters
//   DEPTH   FIFO depth in 128-bit pixel entries
//   ADDR_W  width of the BRAM word address
//
// Ports
//   clk, reset              single clock, synchronous active-high reset
//   start                   one-cycle pulse: load base_addr/num_pixels, run
//   base_addr, num_pixels   job description (num_pixels may be 0)
//   valid, OFM_0..OFM_15    PE array outputs
//   we_OFM, addr_OFM,
//   data_out_OFM            BRAM write port (registered; hold when idle)
//   busy                    job running
//   done                    one-cycle pulse after the last word is written
//   overflow                sticky: a capture was dropped, FIFO full
//   err_partial             sticky: valid was partially set during a job
module ofm_writer #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       num_pixels,
  input  logic [15:0]       valid,
  input  logic [7:0]        OFM_0,
  input  logic [7:0]        OFM_1,
  input  logic [7:0]        OFM_2,
  input  logic [7:0]        OFM_3,
  input  logic [7:0]        OFM_4,
  input  logic [7:0]        OFM_5,
  input  logic [7:0]        OFM_6,
  input  logic [7:0]        OFM_7,
  input  logic [7:0]        OFM_8,
  input  logic [7:0]        OFM_9,
  input  logic [7:0]        OFM_10,
  input  logic [7:0]        OFM_11,
  input  logic [7:0]        OFM_12,
  input  logic [7:0]        OFM_13,
  input  logic [7:0]        OFM_14,
  input  logic [7:0]        OFM_15,
  output logic              we_OFM,
  output logic [ADDR_W-1:0] addr_OFM,
  output logic [31:0]       data_out_OFM,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              err_partial
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Circular pointer increment that also works for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [1:0]          word_q, word_d;
  logic [15:0]         captured_q, captured_d;
  logic [15:0]         drained_q, drained_d;
  logic [15:0]         num_q, num_d;
  logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic                perr_q, perr_d;

  logic [127:0]        mem_q [DEPTH];
  logic [127:0]        head_s;
  logic [127:0]        pixel_s;
  logic [31:0]         word_s;
  logic                full_valid_s;
  logic                part_valid_s;
  logic                pop_s;
  logic                space_s;
  logic                push_s;

  assign pixel_s = {OFM_0, OFM_1, OFM_2,  OFM_3,  OFM_4,  OFM_5,  OFM_6,  OFM_7,
                    OFM_8, OFM_9, OFM_10, OFM_11, OFM_12, OFM_13, OFM_14, OFM_15};
  assign head_s  = mem_q[rd_ptr_q];

  // Select the 32-bit slice of the head entry for the current word index.
  always_comb begin
    word_s = 32'h0000_0000;
    case (word_q)
      2'd0:    word_s = head_s[127:96];
      2'd1:    word_s = head_s[95:64];
      2'd2:    word_s = head_s[63:32];
      2'd3:    word_s = head_s[31:0];
      default: word_s = 32'h0000_0000;
    endcase
  end

  // Next-state logic: restart, drain, capture and FSM.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    word_d      = word_q;
    captured_d  = captured_q;
    drained_d   = drained_q;
    num_d       = num_q;
    next_addr_d = next_addr_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    ovf_d       = ovf_q;
    perr_d      = perr_q;
    push_s      = 1'b0;

    full_valid_s = (valid == 16'hFFFF);
    part_valid_s = (valid != 16'h0000) && !full_valid_s;
    // The head entry leaves the FIFO together with its last word.
    pop_s        = (count_q != CNT_W'(0)) && (word_q == 2'd3);
    space_s      = (count_q < CNT_W'(DEPTH)) || pop_s;

    if (start) begin
      // Start (including a restart mid-job) flushes everything in flight.
      state_d     = RUN;
      num_d       = num_pixels;
      next_addr_d = base_addr;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      word_d      = 2'd0;
      captured_d  = 16'h0000;
      drained_d   = 16'h0000;
      ovf_d       = 1'b0;
      perr_d      = 1'b0;
      count_d     = '0;
    end else begin
      if (pop_s || (count_q != CNT_W'(0))) begin
        we_d        = 1'b1;
        addr_d      = next_addr_q;
        data_d      = word_s;
        next_addr_d = next_addr_q + ADDR_W'(1);
        if (pop_s) begin
          word_d    = 2'd0;
          rd_ptr_d  = ptr_inc(rd_ptr_q);
          drained_d = drained_q + 16'd1;
        end else begin
          word_d    = word_q + 2'd1;
        end
      end else begin
        word_d = word_q;
      end

      if (state_q == RUN) begin
        if (full_valid_s) begin
          if (captured_q < num_q) begin
            if (space_s) begin
              push_s     = 1'b1;
              wr_ptr_d   = ptr_inc(wr_ptr_q);
              captured_d = captured_q + 16'd1;
            end else begin
              ovf_d = 1'b1;
            end
          end else begin
            push_s = 1'b0;
          end
        end else if (part_valid_s) begin
          perr_d = 1'b1;
        end else begin
          push_s = 1'b0;
        end
      end else begin
        push_s = 1'b0;
      end

      count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);

      case (state_q)
        IDLE:    state_d = IDLE;
        // drained_q reaches num_q while the final word is on the BRAM port.
        RUN:     state_d = (drained_q == num_q) ? DONE : RUN;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      word_q      <= 2'd0;
      captured_q  <= 16'h0000;
      drained_q   <= 16'h0000;
      num_q       <= 16'h0000;
      next_addr_q <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= 32'h0000_0000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      word_q      <= word_d;
      captured_q  <= captured_d;
      drained_q   <= drained_d;
      num_q       <= num_d;
      next_addr_q <= next_addr_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      perr_q      <= perr_d;
    end
  end

  // FIFO storage; contents need no reset because count_q gates all reads.
  always_ff @(posedge clk) begin
    if (!reset && push_s) begin
      mem_q[wr_ptr_q] <= pixel_s;
    end
  end

  assign we_OFM       = we_q;
  assign addr_OFM     = addr_q;
  assign data_out_OFM = data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign overflow     = ovf_q;
  assign err_partial  = perr_q;

endmodule

// File: tb/tb_ofm_writer.sv
// Testbench for ofm_writer: expected BRAM writes are queued when pixels are
// driven and compared by a write monitor; per-scenario tasks check control
// outputs inline.
module tb_ofm_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] num_pixels;
  logic [15:0] valid;
  logic [7:0]  ofm [16];
  logic        we_OFM;
  logic [31:0] addr_OFM;
  logic [31:0] data_out_OFM;
  logic        busy, done, overflow, err_partial;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  errors      = 0;
  int  checks      = 0;
  int  writes      = 0;
  int  done_pulses = 0;

  always #5 clk = ~clk;

  ofm_writer #(.DEPTH(2), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_pixels(num_pixels), .valid(valid),
    .OFM_0(ofm[0]),   .OFM_1(ofm[1]),   .OFM_2(ofm[2]),   .OFM_3(ofm[3]),
    .OFM_4(ofm[4]),   .OFM_5(ofm[5]),   .OFM_6(ofm[6]),   .OFM_7(ofm[7]),
    .OFM_8(ofm[8]),   .OFM_9(ofm[9]),   .OFM_10(ofm[10]), .OFM_11(ofm[11]),
    .OFM_12(ofm[12]), .OFM_13(ofm[13]), .OFM_14(ofm[14]), .OFM_15(ofm[15]),
    .we_OFM(we_OFM), .addr_OFM(addr_OFM), .data_out_OFM(data_out_OFM),
    .busy(busy), .done(done), .overflow(overflow), .err_partial(err_partial)
  );

  // Write monitor: every BRAM write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (done === 1'b1) done_pulses++;
    if (we_OFM === 1'b1) begin
      writes++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: addr=%h data=%h, required no write", addr_OFM, data_out_OFM);
      end else begin
        mon_e = exp_q.pop_front();
        if (addr_OFM !== mon_e.addr || data_out_OFM !== mon_e.data) begin
          errors++;
          $display("FAIL wr_data: addr=%h data=%h, required addr=%h data=%h",
                   addr_OFM, data_out_OFM, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pixel(input logic [127:0] px);
    for (int k = 0; k < 16; k++) ofm[k] = px[127-8*k -: 8];
  endtask

  task automatic expect_word(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic expect_pixel(input logic [31:0] a, input logic [127:0] px);
    for (int j = 0; j < 4; j++) expect_word(a + 32'(j), px[127-32*j -: 32]);
  endtask

  task automatic do_start(input logic [31:0] b, input logic [15:0] n);
    start = 1'b1; base_addr = b; num_pixels = n;
    tick();
    start = 1'b0;
  endtask

  task automatic capture(input logic [127:0] px);
    set_pixel(px);
    valid = 16'hFFFF;
    tick();
    valid = 16'h0000;
  endtask

  function automatic logic [127:0] rand_px();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic wait_done(input string name, input int max_cyc);
    int n = 0;
    while (done !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout: done=%b after %0d cycles, required 1", name, done, n);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; valid = 16'hFFFF; base_addr = 32'h1234; num_pixels = 16'd5;
    tick(); tick();
    checks++; if (we_OFM !== 1'b0) begin errors++; $display("FAIL rst_we: got %b, required 0", we_OFM); end
    checks++; if (addr_OFM !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h, required 0", addr_OFM); end
    checks++; if (data_out_OFM !== 32'h0) begin errors++; $display("FAIL rst_data: got %h, required 0", data_out_OFM); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b, required 0", done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b, required 0", overflow); end
    checks++; if (err_partial !== 1'b0) begin errors++; $display("FAIL rst_perr: got %b, required 0", err_partial); end
    reset = 1'b0; start = 1'b0; valid = 16'h0000;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy: got %b, required 0", busy); end
  endtask

  task automatic test_single();
    do_start(32'h100, 16'd1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b, required 1", busy); end
    for (int k = 0; k < 16; k++) ofm[k] = 8'(k);
    expect_word(32'h100, 32'h0001_0203);
    expect_word(32'h101, 32'h0405_0607);
    expect_word(32'h102, 32'h0809_0A0B);
    expect_word(32'h103, 32'h0C0D_0E0F);
    valid = 16'hFFFF;
    tick();
    valid = 16'h0000;
    checks++; if (we_OFM !== 1'b0) begin errors++; $display("FAIL single_lat0: we=%b, required 0", we_OFM); end
    tick();
    checks++; if (we_OFM !== 1'b1 || addr_OFM !== 32'h100) begin
      errors++; $display("FAIL single_lat1: we=%b addr=%h, required 1 100", we_OFM, addr_OFM);
    end
    tick(); tick(); tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_early: got %b, required 0", done); end
    tick();
    checks++; if (done !== 1'b1 || we_OFM !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_done: done=%b we=%b busy=%b, required 1 0 0", done, we_OFM, busy);
    end
    checks++; if (addr_OFM !== 32'h103 || data_out_OFM !== 32'h0C0D_0E0F) begin
      errors++; $display("FAIL single_hold: addr=%h data=%h, required 103 0c0d0e0f", addr_OFM, data_out_OFM);
    end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got %b, required 0", done); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL single_left: %0d words pending, required 0", exp_q.size()); end
  endtask

  task automatic test_streaming();
    logic [31:0]  b = 32'hFFFF_FFA0;
    logic [127:0] px;
    int w0 = writes;
    int d0 = done_pulses;
    do_start(b, 16'd50);
    for (int p = 0; p < 50; p++) begin
      px = rand_px();
      expect_pixel(b + 32'(4*p), px);
      capture(px);
      repeat (35) tick();
    end
    checks++; if (writes - w0 != 200) begin errors++; $display("FAIL stream_writes: got %0d, required 200", writes - w0); end
    checks++; if (done_pulses - d0 != 1) begin errors++; $display("FAIL stream_done: got %0d pulses, required 1", done_pulses - d0); end
    check_bit("stream_ovf", overflow, 1'b0);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stream_left: %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_burst();
    logic [127:0] px [5];
    int w0 = writes;
    int d0 = done_pulses;
    for (int i = 0; i < 5; i++) px[i] = rand_px();
    // Captures 3 and 4 meet a full FIFO; capture 5 lands with the first pop.
    expect_pixel(32'h200, px[0]);
    expect_pixel(32'h204, px[1]);
    expect_pixel(32'h208, px[4]);
    do_start(32'h200, 16'd5);
    for (int i = 0; i < 5; i++) begin
      set_pixel(px[i]);
      valid = 16'hFFFF;
      tick();
    end
    valid = 16'h0000;
    check_bit("burst_ovf", overflow, 1'b1);
    repeat (20) tick();
    checks++; if (writes - w0 != 12) begin errors++; $display("FAIL burst_writes: got %0d, required 12", writes - w0); end
    check_bit("burst_busy", busy, 1'b1);
    checks++; if (done_pulses != d0) begin errors++; $display("FAIL burst_done: got %0d pulses, required 0", done_pulses - d0); end
  endtask

  task automatic test_partial();
    logic [127:0] px0 = rand_px();
    logic [127:0] px1 = rand_px();
    int w0 = writes;
    do_start(32'h300, 16'd2);
    check_bit("partial_ovf_clr", overflow, 1'b0);
    valid = 16'h7FFF;
    tick();
    valid = 16'h0000;
    check_bit("partial_flag", err_partial, 1'b1);
    repeat (5) tick();
    checks++; if (writes != w0) begin errors++; $display("FAIL partial_push: got %0d writes, required 0", writes - w0); end
    expect_pixel(32'h300, px0);
    capture(px0);
    repeat (7) tick();
    expect_pixel(32'h304, px1);
    capture(px1);
    wait_done("partial", 20);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL partial_left: %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_restart();
    logic [127:0] pa = rand_px();
    logic [127:0] pb = rand_px();
    do_start(32'h400, 16'd3);
    valid = 16'h00F0;
    tick();
    check_bit("restart_perr_set", err_partial, 1'b1);
    expect_word(32'h400, pa[127:96]);
    expect_word(32'h401, pa[95:64]);
    capture(pa);
    tick();
    tick();
    do_start(32'h500, 16'd1);
    check_bit("restart_abort_we", we_OFM, 1'b0);
    check_bit("restart_perr_clr", err_partial, 1'b0);
    check_bit("restart_busy", busy, 1'b1);
    repeat (4) tick();
    expect_pixel(32'h500, pb);
    capture(pb);
    wait_done("restart", 20);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL restart_left: %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] px = rand_px();
    int w0;
    do_start(32'h600, 16'd1);
    expect_word(32'h600, px[127:96]);
    expect_word(32'h601, px[95:64]);
    capture(px);
    tick();
    tick();
    w0 = writes;
    reset = 1'b1;
    tick();
    check_bit("rstmid_we", we_OFM, 1'b0);
    check_bit("rstmid_busy", busy, 1'b0);
    checks++; if (addr_OFM !== 32'h0 || data_out_OFM !== 32'h0) begin
      errors++; $display("FAIL rstmid_bus: addr=%h data=%h, required 0 0", addr_OFM, data_out_OFM);
    end
    reset = 1'b0;
    repeat (10) tick();
    checks++; if (writes - w0 != 1) begin errors++; $display("FAIL rstmid_writes: got %0d, required 1", writes - w0); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rstmid_left: %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_zero();
    int w0 = writes;
    do_start(32'h700, 16'd0);
    check_bit("zero_busy", busy, 1'b1);
    check_bit("zero_done_early", done, 1'b0);
    tick();
    check_bit("zero_busy_end", busy, 1'b0);
    check_bit("zero_done", done, 1'b1);
    tick();
    check_bit("zero_done_pulse", done, 1'b0);
    checks++; if (writes != w0) begin errors++; $display("FAIL zero_writes: got %0d, required 0", writes - w0); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; valid = 16'h0000; base_addr = 32'h0; num_pixels = 16'h0;
    for (int k = 0; k < 16; k++) ofm[k] = 8'h00;
    test_reset();
    test_single();
    test_streaming();
    test_burst();
    test_partial();
    test_restart();
    test_reset_mid();
    test_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
